// File: rtl/insfetch_bp.sv
// Instruction fetch unit with a 2-bit-counter branch history table.
// Define IF_BHT_EN to enable BHT prediction; otherwise branches are predicted not-taken.
module insfetch_bp #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned BHT_BITS = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic [31:0] new_pc,
    input  logic        is_b_res,
    input  logic [7:0]  b_res_pc_part,
    input  logic        b_res_jmp,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_ins,
    input  logic        dec_ready,
    output logic        if_valid,
    output logic [31:0] if_ins,
    output logic [31:0] if_pc,
    output logic        if_pred_jmp,
    output logic [31:0] if_another_addr,
    input  logic        jalr_done,
    input  logic [31:0] jalr_target
);

    localparam int unsigned XLEN      = 32;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WAIT_MEM  = 2'd1,
        HOLD      = 2'd2,
        WAIT_JALR = 2'd3
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic              is_jalr_q;
    logic              ic_req_q;
    logic [XLEN-1:0]   ic_addr_q;
    logic              if_valid_q;
    logic [XLEN-1:0]   if_ins_q;
    logic [XLEN-1:0]   if_pc_q;
    logic              if_pred_jmp_q;
    logic [XLEN-1:0]   if_another_q;

    logic              bht_taken;
    logic [XLEN-1:0]   next_pc_d;
    logic [XLEN-1:0]   another_d;
    logic              pred_d;
    logic              is_jalr_d;

`ifdef IF_BHT_EN
    localparam int unsigned BHT_DEPTH = 1 << BHT_BITS;

    logic [1:0]          bht_q [BHT_DEPTH];
    logic [BHT_BITS-1:0] upd_idx;

    assign upd_idx   = BHT_BITS'(b_res_pc_part);
    assign bht_taken = bht_q[ic_addr_q[BHT_BITS:1]][1];

    // Saturating counter update; a same-cycle lookup reads the old value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (rdy_in && is_b_res) begin
            if (b_res_jmp && (bht_q[upd_idx] != 2'b11)) begin
                bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
            end else if (!b_res_jmp && (bht_q[upd_idx] != 2'b00)) begin
                bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
            end
        end
    end
`else
    logic                unused_bres;
    logic [BHT_BITS-1:0] unused_idx;

    assign bht_taken   = 1'b0;
    assign unused_bres = ^{is_b_res, b_res_pc_part, b_res_jmp};
    assign unused_idx  = ic_addr_q[BHT_BITS:1];
`endif

    // Pre-decode of the returning word to choose the next fetch PC.
    always_comb begin
        logic [XLEN-1:0] j_imm;
        logic [XLEN-1:0] b_imm;
        logic [XLEN-1:0] seq_pc;
        logic [XLEN-1:0] b_tgt;

        next_pc_d = ic_addr_q + XLEN'(4);
        another_d = '0;
        pred_d    = 1'b0;
        is_jalr_d = 1'b0;

        j_imm  = {{12{ic_ins[31]}}, ic_ins[19:12], ic_ins[20], ic_ins[30:21], 1'b0};
        b_imm  = {{20{ic_ins[31]}}, ic_ins[7], ic_ins[30:25], ic_ins[11:8], 1'b0};
        seq_pc = ic_addr_q + XLEN'(4);
        b_tgt  = ic_addr_q + b_imm;

        case (ic_ins[6:0])
            OP_JAL: begin
                next_pc_d = ic_addr_q + j_imm;
                pred_d    = 1'b1;
            end
            OP_BRANCH: begin
                if (bht_taken) begin
                    next_pc_d = b_tgt;
                    another_d = seq_pc;
                    pred_d    = 1'b1;
                end else begin
                    next_pc_d = seq_pc;
                    another_d = b_tgt;
                end
            end
            OP_JALR: begin
                is_jalr_d = 1'b1;
            end
            default: begin
                next_pc_d = seq_pc;
            end
        endcase
    end

    // Fetch sequencer; rob_clear overrides everything but reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            is_jalr_q     <= 1'b0;
            ic_req_q      <= 1'b0;
            ic_addr_q     <= '0;
            if_valid_q    <= 1'b0;
            if_ins_q      <= '0;
            if_pc_q       <= '0;
            if_pred_jmp_q <= 1'b0;
            if_another_q  <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                pc_q       <= new_pc;
                ic_req_q   <= 1'b0;
                if_valid_q <= 1'b0;
                state_q    <= FETCH;
            end else begin
                case (state_q)
                    FETCH: begin
                        ic_req_q  <= 1'b1;
                        ic_addr_q <= pc_q;
                        state_q   <= WAIT_MEM;
                    end
                    WAIT_MEM: begin
                        if (ic_valid) begin
                            if_ins_q      <= ic_ins;
                            if_pc_q       <= ic_addr_q;
                            if_valid_q    <= 1'b1;
                            if_pred_jmp_q <= pred_d;
                            if_another_q  <= another_d;
                            is_jalr_q     <= is_jalr_d;
                            pc_q          <= next_pc_d;
                            ic_req_q      <= 1'b0;
                            state_q       <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (if_valid_q && dec_ready) begin
                            if_valid_q <= 1'b0;
                            if (is_jalr_q) begin
                                state_q <= WAIT_JALR;
                            end else begin
                                ic_req_q  <= 1'b1;
                                ic_addr_q <= pc_q;
                                state_q   <= WAIT_MEM;
                            end
                        end
                    end
                    WAIT_JALR: begin
                        if (jalr_done) begin
                            pc_q    <= jalr_target;
                            state_q <= FETCH;
                        end
                    end
                    default: begin
                        state_q <= FETCH;
                    end
                endcase
            end
        end
    end

    assign ic_req          = ic_req_q;
    assign ic_addr         = ic_addr_q;
    assign if_valid        = if_valid_q;
    assign if_ins          = if_ins_q;
    assign if_pc           = if_pc_q;
    assign if_pred_jmp     = if_pred_jmp_q;
    assign if_another_addr = if_another_q;

endmodule

// File: tb/tb_insfetch_bp.sv
// Directed self-checking bench for insfetch_bp (honours IF_BHT_EN when defined).
module tb_insfetch_bp;

    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] ADDI2 = 32'h0020_0113;
    localparam logic [31:0] JAL   = 32'h1000_00EF;
    localparam logic [31:0] BEQ   = 32'hFE00_0CE3;
    localparam logic [31:0] JALR  = 32'h0000_80E7;
`ifdef IF_BHT_EN
    localparam bit BHT_ON = 1'b1;
`else
    localparam bit BHT_ON = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear, is_b_res, b_res_jmp;
    logic [31:0] new_pc, ic_ins, jalr_target;
    logic [7:0]  b_res_pc_part;
    logic        ic_valid, dec_ready, jalr_done;
    logic        ic_req, if_valid, if_pred_jmp;
    logic [31:0] ic_addr, if_ins, if_pc, if_another_addr;

    int n_cmp = 0;
    int n_bad = 0;

    insfetch_bp dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_clear(rob_clear), .new_pc(new_pc),
        .is_b_res(is_b_res), .b_res_pc_part(b_res_pc_part), .b_res_jmp(b_res_jmp),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_ins(ic_ins),
        .dec_ready(dec_ready), .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc),
        .if_pred_jmp(if_pred_jmp), .if_another_addr(if_another_addr),
        .jalr_done(jalr_done), .jalr_target(jalr_target)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            if (ic_req === 1'b1) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic redirect(input logic [31:0] a);
        rob_clear = 1'b1;
        new_pc    = a;
        tick();
        rob_clear = 1'b0;
        new_pc    = '0;
    endtask

    task automatic serve(input logic [31:0] ins);
        ic_valid = 1'b1;
        ic_ins   = ins;
        tick();
        ic_valid = 1'b0;
        ic_ins   = '0;
    endtask

    task automatic pulse_bres(input logic jmp);
        is_b_res      = 1'b1;
        b_res_pc_part = 8'h10;
        b_res_jmp     = jmp;
        tick();
        is_b_res      = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({ic_req, ic_addr, if_valid, if_pred_jmp} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_ctl: got req=%b addr=%h v=%b p=%b expected all 0", ic_req, ic_addr, if_valid, if_pred_jmp);
        end
        n_cmp++;
        if ({if_ins, if_pc, if_another_addr} !== 96'd0) begin
            n_bad++;
            $display("FAIL reset_data: got ins=%h pc=%h another=%h expected 0", if_ins, if_pc, if_another_addr);
        end
        rst_in = 1'b0;
        tick();
        n_cmp++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", ic_req, ic_addr);
        end
    endtask

    task automatic test_sequential();
        serve(ADDI);
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_ins !== ADDI || if_pred_jmp !== 1'b0 || if_another_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL addi_out: got v=%b pc=%h ins=%h p=%b an=%h expected 1/0/%h/0/0", if_valid, if_pc, if_ins, if_pred_jmp, if_another_addr, ADDI);
        end
        tick();
        n_cmp++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h4 || if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL addi_next: got req=%b addr=%h v=%b expected 1/00000004/0", ic_req, ic_addr, if_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 3; k++) begin
            serve(ADDI2);
            tick();
            n_cmp++;
            if (ic_req !== 1'b1 || ic_addr !== 32'(4 * (k + 1))) begin
                n_bad++;
                $display("FAIL b2b_%0d: got req=%b addr=%h expected 1/%h", k, ic_req, ic_addr, 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_jal();
        bit ok;
        redirect(32'h10);
        wait_req(ok);
        serve(JAL);
        n_cmp++;
        if (!ok || if_pc !== 32'h10 || if_pred_jmp !== 1'b1 || if_another_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL jal_out: got ok=%b pc=%h p=%b an=%h expected 1/00000010/1/0", ok, if_pc, if_pred_jmp, if_another_addr);
        end
        tick();
        n_cmp++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h110) begin
            n_bad++;
            $display("FAIL jal_next: got req=%b addr=%h expected 1/00000110", ic_req, ic_addr);
        end
    endtask

    task automatic fetch_beq(input string nm, input logic pe, input logic [31:0] ae, input logic [31:0] ne);
        bit ok;
        redirect(32'h20);
        wait_req(ok);
        serve(BEQ);
        n_cmp++;
        if (!ok || if_pc !== 32'h20 || if_pred_jmp !== pe || if_another_addr !== ae) begin
            n_bad++;
            $display("FAIL %s_out: got ok=%b pc=%h p=%b an=%h expected 1/00000020/%b/%h", nm, ok, if_pc, if_pred_jmp, if_another_addr, pe, ae);
        end
        tick();
        n_cmp++;
        if (ic_req !== 1'b1 || ic_addr !== ne) begin
            n_bad++;
            $display("FAIL %s_next: got req=%b addr=%h expected 1/%h", nm, ic_req, ic_addr, ne);
        end
    endtask

    task automatic test_branch();
        bit ok;
        fetch_beq("beq_fresh", 1'b0, 32'h18, 32'h24);
        pulse_bres(1'b1);
        pulse_bres(1'b1);
        fetch_beq("beq_trained", BHT_ON, BHT_ON ? 32'h24 : 32'h18, BHT_ON ? 32'h18 : 32'h24);
        pulse_bres(1'b1);
        pulse_bres(1'b0);
        // Lookup coincides with a not-taken update that crosses the threshold.
        redirect(32'h20);
        wait_req(ok);
        is_b_res      = 1'b1;
        b_res_pc_part = 8'h10;
        b_res_jmp     = 1'b0;
        serve(BEQ);
        is_b_res      = 1'b0;
        n_cmp++;
        if (!ok || if_pred_jmp !== BHT_ON) begin
            n_bad++;
            $display("FAIL beq_same_cycle: got ok=%b p=%b expected 1/%b", ok, if_pred_jmp, BHT_ON);
        end
        tick();
        fetch_beq("beq_untrained", 1'b0, 32'h18, 32'h24);
    endtask

    task automatic test_jalr();
        bit ok;
        int seen;
        redirect(32'h40);
        wait_req(ok);
        serve(JALR);
        n_cmp++;
        if (!ok || if_pc !== 32'h40 || if_pred_jmp !== 1'b0 || if_another_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL jalr_out: got ok=%b pc=%h p=%b an=%h expected 1/00000040/0/0", ok, if_pc, if_pred_jmp, if_another_addr);
        end
        tick();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (ic_req !== 1'b0) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0 || if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL jalr_wait: got %0d request cycles v=%b expected 0/0", seen, if_valid);
        end
        jalr_done   = 1'b1;
        jalr_target = 32'h200;
        tick();
        jalr_done   = 1'b0;
        jalr_target = '0;
        n_cmp++;
        if (ic_req !== 1'b0) begin
            n_bad++;
            $display("FAIL jalr_fetch_state: got req=%b expected 0", ic_req);
        end
        tick();
        n_cmp++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h200) begin
            n_bad++;
            $display("FAIL jalr_target: got req=%b addr=%h expected 1/00000200", ic_req, ic_addr);
        end
    endtask

    task automatic test_clear();
        rob_clear = 1'b1;
        new_pc    = 32'h80;
        ic_valid  = 1'b1;
        ic_ins    = ADDI;
        tick();
        rob_clear = 1'b0;
        ic_valid  = 1'b0;
        n_cmp++;
        if (if_valid !== 1'b0 || ic_req !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_drop: got v=%b req=%b expected 0/0", if_valid, ic_req);
        end
        tick();
        n_cmp++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h80) begin
            n_bad++;
            $display("FAIL clear_refetch: got req=%b addr=%h expected 1/00000080", ic_req, ic_addr);
        end
        dec_ready = 1'b0;
        serve(ADDI);
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'h80) begin
            n_bad++;
            $display("FAIL clear_hold_pre: got v=%b pc=%h expected 1/00000080", if_valid, if_pc);
        end
        redirect(32'h100);
        n_cmp++;
        if (if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_hold: got v=%b expected 0", if_valid);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        wait_req(ok);
        n_cmp++;
        if (!ok || ic_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL stall_req: got ok=%b addr=%h expected 1/00000100", ok, ic_addr);
        end
        serve(ADDI2);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (if_valid !== 1'b1 || if_ins !== ADDI2 || if_pc !== 32'h100 || ic_req !== 1'b0) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
        end
        dec_ready = 1'b1;
        tick();
        n_cmp++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h104 || if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_release: got req=%b addr=%h v=%b expected 1/00000104/0", ic_req, ic_addr, if_valid);
        end
    endtask

    task automatic test_rdy();
        int bad;
        rdy_in   = 1'b0;
        ic_valid = 1'b1;
        ic_ins   = ADDI;
        bad      = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ic_req !== 1'b1 || ic_addr !== 32'h104 || if_valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL rdy_freeze: got %0d changed cycles expected 0", bad);
        end
        rdy_in   = 1'b1;
        ic_valid = 1'b0;
        tick();
        n_cmp++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h104 || if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rdy_resume: got req=%b addr=%h v=%b expected 1/00000104/0", ic_req, ic_addr, if_valid);
        end
        serve(ADDI);
        dec_ready = 1'b0;
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'h104) begin
            n_bad++;
            $display("FAIL rdy_serve: got v=%b pc=%h expected 1/00000104", if_valid, if_pc);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_in = 1'b1;
        #1;
        n_cmp++;
        if ({ic_req, ic_addr, if_valid, if_ins, if_pc, if_pred_jmp, if_another_addr} !== 131'd0) begin
            n_bad++;
            $display("FAIL async_reset: got req=%b addr=%h v=%b ins=%h pc=%h expected all 0", ic_req, ic_addr, if_valid, if_ins, if_pc);
        end
        tick();
        rst_in    = 1'b0;
        dec_ready = 1'b1;
        tick();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; new_pc = '0;
        is_b_res = 1'b0; b_res_pc_part = '0; b_res_jmp = 1'b0;
        ic_valid = 1'b0; ic_ins = '0; dec_ready = 1'b1;
        jalr_done = 1'b0; jalr_target = '0;
        test_reset();
        test_sequential();
        test_back_to_back();
        test_jal();
        test_branch();
        test_jalr();
        test_clear();
        test_stall();
        test_rdy();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/insfetch_bp.md
Name: insfetch_bp

Overview:
- Instruction fetch unit with integrated branch predictor.
- Sequences the PC, requests instruction words from the icache, pre-decodes jal/branch/jalr to pick the next PC, and hands instructions to the decoder with a valid/ready handshake.
- Consumes the ROB's commit-side branch feedback (is_b_res/b_res_pc_part/b_res_jmp) and its misprediction redirect (rob_clear/new_pc). It is the receiving end of the ROB-to-fetch interface.

Parameters:
- RESET_PC, 32'h0, PC fetched first after reset.
- BHT_BITS, 8, BHT index width. Index = pc[BHT_BITS:1], so the BHT has 256 entries.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global ready; low freezes all state.
- rob_clear  in  1  misprediction flush, one-cycle pulse.
- new_pc  in  32  redirect target, valid with rob_clear.
- is_b_res  in  1  committed-branch outcome valid.
- b_res_pc_part  in  8  pc[8:1] of committed branch.
- b_res_jmp  in  1  actual outcome of committed branch: 1 = taken.
- ic_req  out  1  icache request, held until ic_valid.
- ic_addr  out  32  fetch address, stable while ic_req.
- ic_valid  in  1  icache data valid for the held ic_addr.
- ic_ins  in  32  instruction word.
- dec_ready  in  1  decoder accepts this cycle; low when ROB/RS/LSB full.
- if_valid  out  1  instruction presented to decoder.
- if_ins  out  32  instruction.
- if_pc  out  32  its PC.
- if_pred_jmp  out  1  predicted taken (jal = 1).
- if_another_addr  out  32  branch target on the non-predicted path; 0 for non-branches.
- jalr_done  in  1  jalr target resolved, one-cycle pulse.
- jalr_target  in  32  resolved jalr target.

Behaviour:
- Reset: pc=RESET_PC. ic_req, ic_addr, if_valid, if_ins, if_pc, if_pred_jmp, if_another_addr are all 0. Every BHT entry = 2'b01 (weakly not-taken). state=FETCH.
- rdy_in=0: no state changes. Async reset still acts.
- FSM states: FETCH, WAIT_MEM, HOLD, WAIT_JALR.
- FETCH: ic_req<=1, ic_addr<=pc; go to WAIT_MEM.
- WAIT_MEM, on ic_valid:
  - Latch if_ins, if_pc=ic_addr, if_valid<=1, ic_req<=0; go to HOLD.
  - Next pc is chosen by opcode ic_ins[6:0]:
    - jal (1101111): pc + J-imm, if_pred_jmp=1.
    - branch (1100011): predict taken iff BHT[pc[8:1]][1]. Taken: next = pc + B-imm, another = pc + 4. Not taken: next = pc + 4, another = pc + B-imm.
    - jalr (1100111): next pc is unknown; if_pred_jmp=0.
    - all others: pc + 4.
  - All additions are 32-bit, wrap-around. Immediates are sign-extended per RV32I (bit 0 = 0).
- HOLD: outputs stay stable until if_valid && dec_ready.
  - On accept: if_valid<=0.
  - If the instruction was jalr: go to WAIT_JALR.
  - Otherwise: ic_req<=1, ic_addr<=next pc, go to WAIT_MEM in the same cycle (no FETCH bubble).
- WAIT_JALR: no requests. On jalr_done: pc<=jalr_target, go to FETCH.
- rob_clear, priority over all FSM activity except reset:
  - pc<=new_pc, ic_req<=0, if_valid<=0, state<=FETCH.
  - An ic_valid in the same cycle is dropped.
  - A jalr_done in the same cycle is ignored.
  - First request for new_pc goes out 2 cycles after the clear.
- Icache contract: ic_valid is only meaningful while ic_req=1. Dropping ic_req aborts the access. The icache returns no stale data after the abort.
- BHT update:
  - On is_b_res (any state, including the rob_clear cycle), saturating 2-bit update of BHT[b_res_pc_part]: taken increments (max 11), not-taken decrements (min 00).
  - A same-cycle lookup of the same index sees the pre-update value.
- Minimum throughput: 1 instruction per 2 cycles with 1-cycle icache and dec_ready tied high.

Optional Feature:
- IF_BHT_EN defined: BHT prediction as above.
- Undefined: no BHT storage; all branches predicted not-taken (if_pred_jmp=0, another = pc + B-imm); is_b_res and b_res_* ignored; jal is still predicted taken.

Test Plan:
- Reset with RESET_PC=0; icache returns addi (0x00100093) -> if_valid, if_pc=0, if_pred_jmp=0; after accept, ic_addr=4.
- jal x1,+0x100 at 0x10 -> if_pred_jmp=1, if_another_addr=0, next ic_addr=0x110.
- beq at 0x20, imm=-8, fresh BHT -> pred 0, ic_addr=0x24, if_another_addr=0x18. Then two is_b_res (pc_part=0x10, jmp=1) -> refetch of 0x20 predicts 1, ic_addr=0x18, if_another_addr=0x24. Under IF_BHT_EN undefined it stays not-taken.
- jalr at 0x40 accepted -> ic_req stays 0 for 10 cycles. jalr_done with target 0x200 -> FETCH, then ic_addr=0x200.
- rob_clear, new_pc=0x80, in WAIT_MEM with ic_valid in the same cycle -> if_valid stays 0, next ic_addr=0x80. Clear during HOLD -> if_valid drops the next cycle.
- dec_ready=0 for 5 cycles in HOLD -> if_ins/if_pc stable, ic_req=0. rdy_in=0 for 3 cycles mid-WAIT_MEM -> ic_addr and state unchanged. rst_in asserted mid-HOLD -> outputs 0 immediately, without waiting for a clock edge.
